// File: rtl/fir_sched_pkg.sv
// -----------------------------------------------------------------------------
// fir_sched_pkg
// Shared types and constants for the multichannel FIR scheduler.
//   sched_state_e : scheduler FSM states (COLLECT gathers a frame, ISSUE streams
//                   it to the FIR core).
//   FIR_*         : default lead count, sample width, core output width and
//                   output rescale shift.
//   sat_narrow()  : clamps a FIR_ACC_W-bit signed value into FIR_DW bits.
// -----------------------------------------------------------------------------
package fir_sched_pkg;

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        ISSUE   = 1'b1
    } sched_state_e;

    localparam int FIR_NCH   = 4;
    localparam int FIR_DW    = 16;
    localparam int FIR_ACC_W = 40;
    localparam int FIR_SHIFT = 23;

    // The value fits in FIR_DW bits exactly when every bit from the DW-1
    // position upward is a copy of the sign bit; otherwise clamp by sign.
    function automatic logic [FIR_DW-1:0] sat_narrow(input logic [FIR_ACC_W-1:0] v);
        logic [FIR_ACC_W-FIR_DW:0] upper_s;
        upper_s = v[FIR_ACC_W-1:FIR_DW-1];
        if ((upper_s == {(FIR_ACC_W-FIR_DW+1){1'b0}}) ||
            (upper_s == {(FIR_ACC_W-FIR_DW+1){1'b1}})) begin
            return v[FIR_DW-1:0];
        end else if (v[FIR_ACC_W-1]) begin
            return {1'b1, {(FIR_DW-1){1'b0}}};
        end else begin
            return {1'b0, {(FIR_DW-1){1'b1}}};
        end
    endfunction

endpackage

// File: rtl/fir_out_scaler.sv
// -----------------------------------------------------------------------------
// fir_out_scaler
// Rescales one FIR core result (arithmetic shift right by SHIFT at ACC_W width)
// and narrows it to DW bits, then registers it together with its lead index.
// Narrowing mode is selected by macro FIR_SCHED_OUT_SAT_EN:
//   defined   -> saturate to the signed DW-bit range
//   undefined -> keep the low DW bits (two's-complement wrap)
// The saturating path uses the package widths, so ACC_W/DW keep their
// package defaults in that build.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   in_valid   : core result strobe
//   in_idx     : lead index the result belongs to
//   in_data    : raw ACC_W-bit core result
//   out_valid  : registered 1-cycle result strobe
//   out_ch     : registered lead index
//   out_data   : registered rescaled sample
// -----------------------------------------------------------------------------
module fir_out_scaler
    import fir_sched_pkg::*;
#(
    parameter int DW    = FIR_DW,
    parameter int ACC_W = FIR_ACC_W,
    parameter int SHIFT = FIR_SHIFT,
    parameter int IDX_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [IDX_W-1:0] in_idx,
    input  logic [ACC_W-1:0] in_data,
    output logic             out_valid,
    output logic [IDX_W-1:0] out_ch,
    output logic [DW-1:0]    out_data
);

    logic [DW-1:0]    narrow_s;
    logic             out_valid_q, out_valid_d;
    logic [IDX_W-1:0] out_ch_q, out_ch_d;
    logic [DW-1:0]    out_data_q, out_data_d;

`ifdef FIR_SCHED_OUT_SAT_EN
    logic signed [ACC_W-1:0] shifted_s;

    // Shift at full accumulator width, then clamp into DW bits.
    always_comb begin
        shifted_s = $signed(in_data) >>> SHIFT;
        narrow_s  = sat_narrow(shifted_s);
    end
`else
    // Shift at full accumulator width, then keep the low DW bits.
    always_comb begin
        narrow_s = DW'($signed(in_data) >>> SHIFT);
    end
`endif

    // Next-state of the output register: capture on a core result, else hold.
    always_comb begin
        out_valid_d = in_valid;
        if (in_valid) begin
            out_ch_d   = in_idx;
            out_data_d = narrow_s;
        end else begin
            out_ch_d   = out_ch_q;
            out_data_d = out_data_q;
        end
    end

    // Output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_ch_q    <= {IDX_W{1'b0}};
            out_data_q  <= {DW{1'b0}};
        end else begin
            out_valid_q <= out_valid_d;
            out_ch_q    <= out_ch_d;
            out_data_q  <= out_data_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_ch    = out_ch_q;
    assign out_data  = out_data_q;

endmodule

// File: rtl/fir_ch_scheduler.sv
// -----------------------------------------------------------------------------
// fir_ch_scheduler
// Time-multiplexes one multichannel FIR core across NCH leads. One sample per
// lead is held until the frame is complete, then the frame is streamed to the
// core in lead order 0..NCH-1 over an AXI-Stream style handshake. Core results
// are tagged with a wrapping lead counter (results are assumed to come back in
// issue order), rescaled and presented per lead.
// Optional feature macro: FIR_SCHED_OUT_SAT_EN (saturating output narrowing,
// see fir_out_scaler).
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset (shared with the core)
//   ch_valid     : per-lead new-sample strobe
//   ch_data      : packed signed samples, lead k at [k*DW +: DW]
//   fir_s_tvalid : sample valid towards the core
//   fir_s_tdata  : sample towards the core
//   fir_s_tready : core ready
//   fir_m_tvalid : core result valid (no backpressure)
//   fir_m_tdata  : core result
//   out_valid    : rescaled result strobe
//   out_ch       : lead index of out_data
//   out_data     : rescaled signed result
//   ch_overrun   : sticky per-lead overrun flags
//   busy         : high while a frame is being issued
// -----------------------------------------------------------------------------
module fir_ch_scheduler
    import fir_sched_pkg::*;
#(
    parameter int NCH   = FIR_NCH,
    parameter int DW    = FIR_DW,
    parameter int ACC_W = FIR_ACC_W,
    parameter int SHIFT = FIR_SHIFT
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NCH-1:0]           ch_valid,
    input  logic [NCH*DW-1:0]        ch_data,
    output logic                     fir_s_tvalid,
    output logic [DW-1:0]            fir_s_tdata,
    input  logic                     fir_s_tready,
    input  logic                     fir_m_tvalid,
    input  logic [ACC_W-1:0]         fir_m_tdata,
    output logic                     out_valid,
    output logic [$clog2(NCH)-1:0]   out_ch,
    output logic [DW-1:0]            out_data,
    output logic [NCH-1:0]           ch_overrun,
    output logic                     busy
);

    localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;

    sched_state_e     state_q, state_d;
    logic [IDX_W-1:0] issue_idx_q, issue_idx_d;
    logic             tvalid_q, tvalid_d;
    logic [DW-1:0]    tdata_q, tdata_d;
    logic             busy_q, busy_d;

    logic [NCH-1:0]   pend_q, pend_d;
    logic [NCH-1:0]   overrun_q, overrun_d;
    logic [DW-1:0]    hold_q [NCH];
    logic [DW-1:0]    hold_d [NCH];
    logic [IDX_W-1:0] out_idx_q, out_idx_d;

    logic             hs_s;
    logic             last_beat_s;
    logic [IDX_W-1:0] next_idx_s;
    logic [NCH-1:0]   hs_lead_s;

    // Handshake decode: which lead (if any) is accepted by the core this cycle.
    always_comb begin
        hs_s        = tvalid_q && fir_s_tready;
        last_beat_s = (issue_idx_q == IDX_W'(NCH-1));
        next_idx_s  = issue_idx_q + {{(IDX_W-1){1'b0}}, 1'b1};
        for (int k = 0; k < NCH; k++) begin
            hs_lead_s[k] = hs_s && (issue_idx_q == IDX_W'(k));
        end
    end

    // Per-lead hold registers: a lead accepts a new sample when it has none
    // pending, or in the very cycle its pending sample is handed to the core
    // (that sample then belongs to the next frame). Otherwise it is dropped
    // and flagged, keeping the held value stable under the handshake.
    always_comb begin
        for (int k = 0; k < NCH; k++) begin
            hold_d[k]    = hold_q[k];
            pend_d[k]    = pend_q[k];
            overrun_d[k] = overrun_q[k];
            if (ch_valid[k]) begin
                if (!pend_q[k] || hs_lead_s[k]) begin
                    hold_d[k] = ch_data[k*DW +: DW];
                    pend_d[k] = 1'b1;
                end else begin
                    overrun_d[k] = 1'b1;
                end
            end else if (hs_lead_s[k]) begin
                pend_d[k] = 1'b0;
            end else begin
                pend_d[k] = pend_q[k];
            end
        end
    end

    // Result lead counter: advances once per core result, wrapping at NCH-1.
    always_comb begin
        if (fir_m_tvalid) begin
            if (out_idx_q == IDX_W'(NCH-1)) begin
                out_idx_d = {IDX_W{1'b0}};
            end else begin
                out_idx_d = out_idx_q + {{(IDX_W-1){1'b0}}, 1'b1};
            end
        end else begin
            out_idx_d = out_idx_q;
        end
    end

    // FSM next state and registered AXIS outputs. tdata is preloaded with the
    // next lead's held sample so it is valid in the same cycle as tvalid; held
    // samples of leads not yet issued cannot change while pending.
    always_comb begin
        state_d     = state_q;
        issue_idx_d = issue_idx_q;
        tvalid_d    = tvalid_q;
        tdata_d     = tdata_q;
        case (state_q)
            COLLECT: begin
                if (&pend_q) begin
                    state_d     = ISSUE;
                    issue_idx_d = {IDX_W{1'b0}};
                    tvalid_d    = 1'b1;
                    tdata_d     = hold_q[0];
                end else begin
                    tvalid_d    = 1'b0;
                end
            end
            ISSUE: begin
                if (hs_s) begin
                    if (last_beat_s) begin
                        state_d     = COLLECT;
                        issue_idx_d = {IDX_W{1'b0}};
                        tvalid_d    = 1'b0;
                    end else begin
                        issue_idx_d = next_idx_s;
                        tvalid_d    = 1'b1;
                        tdata_d     = hold_q[next_idx_s];
                    end
                end else begin
                    tvalid_d    = tvalid_q;
                end
            end
            default: begin
                state_d     = COLLECT;
                issue_idx_d = {IDX_W{1'b0}};
                tvalid_d    = 1'b0;
            end
        endcase
        busy_d = (state_d == ISSUE);
    end

    // Scheduler FSM with its registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= COLLECT;
            issue_idx_q <= {IDX_W{1'b0}};
            tvalid_q    <= 1'b0;
            tdata_q     <= {DW{1'b0}};
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            issue_idx_q <= issue_idx_d;
            tvalid_q    <= tvalid_d;
            tdata_q     <= tdata_d;
            busy_q      <= busy_d;
        end
    end

    // Frame gathering state, overrun flags and result lead counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q    <= {NCH{1'b0}};
            overrun_q <= {NCH{1'b0}};
            out_idx_q <= {IDX_W{1'b0}};
            for (int k = 0; k < NCH; k++) begin
                hold_q[k] <= {DW{1'b0}};
            end
        end else begin
            pend_q    <= pend_d;
            overrun_q <= overrun_d;
            out_idx_q <= out_idx_d;
            for (int k = 0; k < NCH; k++) begin
                hold_q[k] <= hold_d[k];
            end
        end
    end

    fir_out_scaler #(
        .DW    (DW),
        .ACC_W (ACC_W),
        .SHIFT (SHIFT),
        .IDX_W (IDX_W)
    ) u_out_scaler (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (fir_m_tvalid),
        .in_idx    (out_idx_q),
        .in_data   (fir_m_tdata),
        .out_valid (out_valid),
        .out_ch    (out_ch),
        .out_data  (out_data)
    );

    assign fir_s_tvalid = tvalid_q;
    assign fir_s_tdata  = tdata_q;
    assign busy         = busy_q;
    assign ch_overrun   = overrun_q;

endmodule

// File: tb/tb_fir_ch_scheduler.sv
module tb_fir_ch_scheduler;

    localparam int NCH   = 4;
    localparam int DW    = 16;
    localparam int ACC_W = 40;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NCH-1:0]    ch_valid;
    logic [NCH*DW-1:0] ch_data;
    logic              fir_s_tvalid;
    logic [DW-1:0]     fir_s_tdata;
    logic              fir_s_tready;
    logic              fir_m_tvalid;
    logic [ACC_W-1:0]  fir_m_tdata;
    logic              out_valid;
    logic [1:0]        out_ch;
    logic [DW-1:0]     out_data;
    logic [NCH-1:0]    ch_overrun;
    logic              busy;

    fir_ch_scheduler dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ch_valid     (ch_valid),
        .ch_data      (ch_data),
        .fir_s_tvalid (fir_s_tvalid),
        .fir_s_tdata  (fir_s_tdata),
        .fir_s_tready (fir_s_tready),
        .fir_m_tvalid (fir_m_tvalid),
        .fir_m_tdata  (fir_m_tdata),
        .out_valid    (out_valid),
        .out_ch       (out_ch),
        .out_data     (out_data),
        .ch_overrun   (ch_overrun),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [15:0] data; int cyc; } beat_t;
    typedef struct { logic [1:0] ch; logic [15:0] data; int cyc; } res_t;

    beat_t beat_q[$];
    res_t  res_q[$];
    int    n_checks = 0;
    int    n_errors = 0;
    int    oc = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_beat(input int v, input int c);
        beat_q.push_back('{16'(v), c});
    endtask

    // Drive one cycle of lead strobes, then release them.
    task automatic strobe(input logic [3:0] mask, input int v0, input int v1, input int v2, input int v3);
        ch_valid = mask;
        ch_data  = {16'(v3), 16'(v2), 16'(v1), 16'(v0)};
        tick();
        ch_valid = '0;
    endtask

    // One core result pulse; expected output one cycle later on the modelled lead.
    task automatic m_pulse(input logic [39:0] d, input logic [15:0] expd);
        res_q.push_back('{2'(oc % 4), expd, cyc + 1});
        oc++;
        fir_m_tvalid = 1'b1;
        fir_m_tdata  = d;
        tick();
        fir_m_tvalid = 1'b0;
    endtask

    // Monitor: every accepted beat towards the core is compared against the scoreboard.
    always @(negedge clk) begin : mon_beats
        beat_t e;
        if (rst_n === 1'b1 && fir_s_tvalid === 1'b1 && fir_s_tready === 1'b1) begin
            if (beat_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL beat_unexpected: got tdata %0h, expected no beat (cycle %0d)", fir_s_tdata, cyc);
            end else begin
                e = beat_q.pop_front();
                check("beat_data", 64'(fir_s_tdata), 64'(e.data));
                if (e.cyc >= 0) check("beat_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    // Monitor: every rescaled result is compared against the scoreboard.
    always @(negedge clk) begin : mon_results
        res_t r;
        if (rst_n === 1'b1 && out_valid === 1'b1) begin
            if (res_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL result_unexpected: got ch %0d data %0h, expected no result (cycle %0d)", out_ch, out_data, cyc);
            end else begin
                r = res_q.pop_front();
                check("result_ch", 64'(out_ch), 64'(r.ch));
                check("result_data", 64'(out_data), 64'(r.data));
                check("result_cycle", 64'(cyc), 64'(r.cyc));
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_tvalid"},  64'(fir_s_tvalid), 64'd0);
        check({tag, "_tdata"},   64'(fir_s_tdata),  64'd0);
        check({tag, "_outv"},    64'(out_valid),    64'd0);
        check({tag, "_outch"},   64'(out_ch),       64'd0);
        check({tag, "_outdata"}, 64'(out_data),     64'd0);
        check({tag, "_overrun"}, 64'(ch_overrun),   64'd0);
        check({tag, "_busy"},    64'(busy),         64'd0);
    endtask

    initial begin
        int c0;
        int c1;
        int bc;
        rst_n        = 1'b0;
        ch_valid     = '0;
        ch_data      = '0;
        fir_s_tready = 1'b1;
        fir_m_tvalid = 1'b0;
        fir_m_tdata  = '0;
        repeat (3) tick();
        check_all_zero("reset");
        rst_n = 1'b1;
        tick();

        // Basic frame: beats on consecutive cycles starting two cycles after the strobe.
        c0 = cyc;
        push_beat(100, c0 + 2); push_beat(-200, c0 + 3);
        push_beat(300, c0 + 4); push_beat(-400, c0 + 5);
        strobe(4'hF, 100, -200, 300, -400);
        check("tvalid_before_issue", 64'(fir_s_tvalid), 64'd0);
        bc = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (busy) bc++;
        end
        check("busy_cycles", 64'(bc), 64'd4);
        check("frame_no_overrun", 64'(ch_overrun), 64'd0);

        // Backpressure on beat 2 for 5 cycles.
        c0 = cyc;
        push_beat(11, c0 + 2); push_beat(22, c0 + 3);
        push_beat(33, c0 + 9); push_beat(44, c0 + 10);
        strobe(4'hF, 11, 22, 33, 44);
        tick(); tick(); tick();
        fir_s_tready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("stall_tvalid", 64'(fir_s_tvalid), 64'd1);
            check("stall_tdata", 64'(fir_s_tdata), 64'd33);
            tick();
        end
        fir_s_tready = 1'b1;
        repeat (6) tick();

        // Overrun: lead 1 strobed twice, the second value is dropped.
        c0 = cyc;
        strobe(4'b0010, 0, 555, 0, 0);
        strobe(4'b0010, 0, 666, 0, 0);
        check("overrun_flag", 64'(ch_overrun), 64'h2);
        push_beat(10, c0 + 4); push_beat(555, c0 + 5);
        push_beat(30, c0 + 6); push_beat(40, c0 + 7);
        strobe(4'b1101, 10, 0, 30, 40);
        repeat (8) tick();

        // Same-cycle reload of lead 0 during its handshake.
        c0 = cyc;
        push_beat(1, c0 + 2); push_beat(2, c0 + 3);
        push_beat(3, c0 + 4); push_beat(4, c0 + 5);
        strobe(4'hF, 1, 2, 3, 4);
        tick();
        strobe(4'b0001, 77, 0, 0, 0);
        repeat (5) tick();
        check("reload_no_overrun", 64'(ch_overrun), 64'h2);
        check("reload_waits_frame", 64'(fir_s_tvalid), 64'd0);
        c1 = cyc;
        push_beat(77, c1 + 2); push_beat(5, c1 + 3);
        push_beat(6, c1 + 4); push_beat(7, c1 + 5);
        strobe(4'b1110, 0, 5, 6, 7);
        repeat (8) tick();

        // Output demux: 8 back-to-back results of 1<<23.
        for (int i = 0; i < 8; i++) m_pulse(40'd1 << 23, 16'd1);
        tick();
        check("out_valid_idle", 64'(out_valid), 64'd0);

        // Scaling boundaries and sign handling.
`ifdef FIR_SCHED_OUT_SAT_EN
        m_pulse(40'h7F_FFFF_FFFF, 16'h7FFF);
        m_pulse(40'h80_0000_0000, 16'h8000);
`else
        m_pulse(40'h7F_FFFF_FFFF, 16'hFFFF);
        m_pulse(40'h80_0000_0000, 16'h0000);
`endif
        m_pulse(40'hFF_FE80_0000, 16'hFFFD);
        m_pulse(40'h00_0280_007B, 16'd5);
        m_pulse(40'd2 << 23, 16'd2);
        m_pulse(40'd7 << 23, 16'd7);
        tick();

        // Reset in the middle of an issued frame (stalled by tready low).
        fir_s_tready = 1'b0;
        strobe(4'hF, 9, 9, 9, 9);
        tick(); tick();
        check("pre_reset_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        tick();
        check_all_zero("midreset_edge");
        rst_n = 1'b1;
        fir_s_tready = 1'b1;
        oc = 0;
        tick();

        // After reset the frame and the result counter restart from lead 0.
        c0 = cyc;
        push_beat(-1, c0 + 2); push_beat(-2, c0 + 3);
        push_beat(-3, c0 + 4); push_beat(-4, c0 + 5);
        strobe(4'hF, -1, -2, -3, -4);
        repeat (6) tick();
        m_pulse(40'd3 << 23, 16'd3);
        repeat (4) tick();

        check("beats_drained", 64'(beat_q.size()), 64'd0);
        check("results_drained", 64'(res_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
